// File: rtl/dmem_port_arbiter_if.sv
// Bus bundle between the two data-memory masters (core, debug/loader), the arbiter and the memory.
// slave is the arbiter's view; master is the view of the requesters and the memory instance.
interface dmem_port_arbiter_if #(
  parameter int unsigned AW     = 32,
  parameter int unsigned DW     = 32,
  parameter int unsigned MEM_AW = 8
);
  logic              cpu_req;
  logic              cpu_we;
  logic [AW-1:0]     cpu_addr;
  logic [DW-1:0]     cpu_wdata;
  logic              cpu_gnt;
  logic              cpu_rvalid;
  logic [DW-1:0]     cpu_rdata;
  logic              cpu_err;
  logic              cpu_stall;

  logic              dbg_req;
  logic              dbg_we;
  logic [AW-1:0]     dbg_addr;
  logic [DW-1:0]     dbg_wdata;
  logic              dbg_lock;
  logic              dbg_gnt;
  logic              dbg_rvalid;
  logic [DW-1:0]     dbg_rdata;
  logic              dbg_err;

  logic              mem_en;
  logic              mem_we;
  logic [MEM_AW-1:0] mem_addr;
  logic [DW-1:0]     mem_wdata;
  logic [DW-1:0]     mem_rdata;

  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
    output cpu_gnt, cpu_rvalid, cpu_rdata, cpu_err, cpu_stall,
    input  dbg_req, dbg_we, dbg_addr, dbg_wdata, dbg_lock,
    output dbg_gnt, dbg_rvalid, dbg_rdata, dbg_err,
    output mem_en, mem_we, mem_addr, mem_wdata,
    input  mem_rdata
  );

  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata,
    input  cpu_gnt, cpu_rvalid, cpu_rdata, cpu_err, cpu_stall,
    output dbg_req, dbg_we, dbg_addr, dbg_wdata, dbg_lock,
    input  dbg_gnt, dbg_rvalid, dbg_rdata, dbg_err,
    input  mem_en, mem_we, mem_addr, mem_wdata,
    output mem_rdata
  );
endinterface

// File: rtl/dmem_port_arbiter.sv
// Shares the single-port data memory between the core load/store port and a debug/loader master,
// alternating on conflicts, with a debug lock for exclusive bursts.
module dmem_port_arbiter #(
  parameter int unsigned AW     = 32,
  parameter int unsigned DW     = 32,
  parameter int unsigned MEM_AW = 8
) (
  input logic                 clk,
  input logic                 reset,
  dmem_port_arbiter_if.slave  bus
);

  typedef enum logic {StArb, StLocked} state_e;
  typedef enum logic {LastCpu, LastDbg} last_e;
  typedef enum logic [1:0] {OwnNone, OwnCpu, OwnDbg} owner_e;

  state_e        state_q, state_d;
  last_e         last_q, last_d;
  owner_e        rd_owner_q, rd_owner_d;
  logic [DW-1:0] cpu_rdata_q, dbg_rdata_q;

  logic cpu_mis, dbg_mis, cpu_ok, dbg_ok;
  logic cpu_gnt, dbg_gnt;
  logic unused_addr_bits;

  assign cpu_mis = (bus.cpu_addr[1:0] != 2'b00);
  assign dbg_mis = (bus.dbg_addr[1:0] != 2'b00);
  assign cpu_ok  = bus.cpu_req & ~cpu_mis;
  assign dbg_ok  = bus.dbg_req & ~dbg_mis;

  // Only addr[MEM_AW+1:2] reaches the memory.
  assign unused_addr_bits = ^{bus.cpu_addr[AW-1:MEM_AW+2], bus.dbg_addr[AW-1:MEM_AW+2]};

  always_comb begin
    cpu_gnt = 1'b0;
    dbg_gnt = 1'b0;
    if (state_q == StLocked) begin
      dbg_gnt = dbg_ok;
    end else if (cpu_ok && dbg_ok) begin
      cpu_gnt = (last_q == LastDbg);
      dbg_gnt = (last_q == LastCpu);
    end else begin
      cpu_gnt = cpu_ok;
      dbg_gnt = dbg_ok;
    end
  end

  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    if (cpu_gnt) begin
      last_d = LastCpu;
    end else if (dbg_gnt) begin
      last_d = LastDbg;
    end
    unique case (state_q)
      StArb: begin
        if (dbg_gnt && bus.dbg_lock) begin
          state_d = StLocked;
        end
      end
      StLocked: begin
        if (!bus.dbg_lock) begin
          state_d = StArb;
          last_d  = LastDbg;
        end
      end
      default: state_d = StArb;
    endcase

    rd_owner_d = OwnNone;
    if (cpu_gnt && !bus.cpu_we) begin
      rd_owner_d = OwnCpu;
    end else if (dbg_gnt && !bus.dbg_we) begin
      rd_owner_d = OwnDbg;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= StArb;
      last_q      <= LastDbg;
      rd_owner_q  <= OwnNone;
      cpu_rdata_q <= '0;
      dbg_rdata_q <= '0;
    end else begin
      state_q    <= state_d;
      last_q     <= last_d;
      rd_owner_q <= rd_owner_d;
      if (rd_owner_q == OwnCpu) begin
        cpu_rdata_q <= bus.mem_rdata;
      end
      if (rd_owner_q == OwnDbg) begin
        dbg_rdata_q <= bus.mem_rdata;
      end
    end
  end

  assign bus.cpu_gnt    = cpu_gnt;
  assign bus.dbg_gnt    = dbg_gnt;
  assign bus.cpu_err    = bus.cpu_req & cpu_mis;
  assign bus.dbg_err    = bus.dbg_req & dbg_mis;
  assign bus.cpu_stall  = bus.cpu_req & ~cpu_gnt & ~cpu_mis;

  assign bus.cpu_rvalid = (rd_owner_q == OwnCpu);
  assign bus.dbg_rvalid = (rd_owner_q == OwnDbg);
  // Read data is forwarded in the return cycle, then held for the non-owning cycles.
  assign bus.cpu_rdata  = (rd_owner_q == OwnCpu) ? bus.mem_rdata : cpu_rdata_q;
  assign bus.dbg_rdata  = (rd_owner_q == OwnDbg) ? bus.mem_rdata : dbg_rdata_q;

  always_comb begin
    bus.mem_en    = cpu_gnt | dbg_gnt;
    bus.mem_we    = 1'b0;
    bus.mem_addr  = '0;
    bus.mem_wdata = '0;
    if (cpu_gnt) begin
      bus.mem_we    = bus.cpu_we;
      bus.mem_addr  = bus.cpu_addr[MEM_AW+1:2];
      bus.mem_wdata = bus.cpu_wdata;
    end else if (dbg_gnt) begin
      bus.mem_we    = bus.dbg_we;
      bus.mem_addr  = bus.dbg_addr[MEM_AW+1:2];
      bus.mem_wdata = bus.dbg_wdata;
    end
  end

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Directed table of per-cycle vectors for dmem_port_arbiter, plus a hand sequence for reset
// in the middle of a locked debug read.
module tb_dmem_port_arbiter;

  logic clk;
  logic reset;
  logic mem_init;
  logic [31:0] mem [256];

  int checks = 0;
  int errors = 0;

  dmem_port_arbiter_if #(.AW(32), .DW(32), .MEM_AW(8)) bus ();

  dmem_port_arbiter #(.AW(32), .DW(32), .MEM_AW(8)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single-port synchronous memory: read data appears the cycle after the strobe.
  always @(posedge clk) begin
    if (mem_init) begin
      for (int i = 0; i < 256; i++) mem[i] <= 32'hA000_0000 + i;
      bus.mem_rdata <= '0;
    end else if (bus.mem_en) begin
      if (bus.mem_we) mem[bus.mem_addr] <= bus.mem_wdata;
      else            bus.mem_rdata <= mem[bus.mem_addr];
    end
  end

  typedef struct {
    logic        cr, cw;
    logic [31:0] ca, cd;
    logic        dr, dw;
    logic [31:0] da, dd;
    logic        dl;
    logic [8:0]  flags;  // cpu_gnt dbg_gnt cpu_err dbg_err cpu_stall mem_en mem_we cpu_rvalid dbg_rvalid
    logic [7:0]  addr;
    logic        k_crd;
    logic [31:0] crd;
    logic        k_drd;
    logic [31:0] drd;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic cr, input logic cw, input logic [31:0] ca, input logic [31:0] cd,
                     input logic dr, input logic dw, input logic [31:0] da, input logic [31:0] dd,
                     input logic dl, input logic [8:0] flags, input logic [7:0] addr,
                     input logic k_crd, input logic [31:0] crd,
                     input logic k_drd, input logic [31:0] drd);
    vec_t v;
    v.cr = cr; v.cw = cw; v.ca = ca; v.cd = cd;
    v.dr = dr; v.dw = dw; v.da = da; v.dd = dd; v.dl = dl;
    v.flags = flags; v.addr = addr;
    v.k_crd = k_crd; v.crd = crd; v.k_drd = k_drd; v.drd = drd;
    vecs.push_back(v);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp_v);
    end
  endtask

  task automatic drive(input logic cr, input logic cw, input logic [31:0] ca, input logic [31:0] cd,
                       input logic dr, input logic dw, input logic [31:0] da,
                       input logic [31:0] dd, input logic dl);
    bus.cpu_req = cr; bus.cpu_we = cw; bus.cpu_addr = ca; bus.cpu_wdata = cd;
    bus.dbg_req = dr; bus.dbg_we = dw; bus.dbg_addr = da; bus.dbg_wdata = dd;
    bus.dbg_lock = dl;
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
  endtask

  initial begin
    vec_t v;
    logic [31:0] exp_wd;
    //   cr cw ca     cd            dr dw da     dd            dl  flags          addr
    add(0, 0, 32'h0,  32'h0,        0, 0, 32'h0,  32'h0,        0, 9'b000000000, 8'd0,
        1, 32'h0, 1, 32'h0);
    // Both load continuously: CPU first, then alternate.
    add(1, 0, 32'h4,  32'h0,        1, 0, 32'h20, 32'h0,        0, 9'b100001000, 8'd1,
        0, 32'h0, 0, 32'h0);
    add(1, 0, 32'h4,  32'h0,        1, 0, 32'h20, 32'h0,        0, 9'b010011010, 8'd8,
        1, 32'hA000_0001, 0, 32'h0);
    add(1, 0, 32'h4,  32'h0,        1, 0, 32'h20, 32'h0,        0, 9'b100001001, 8'd1,
        0, 32'h0, 1, 32'hA000_0008);
    add(1, 0, 32'h4,  32'h0,        1, 0, 32'h20, 32'h0,        0, 9'b010011010, 8'd8,
        1, 32'hA000_0001, 0, 32'h0);
    add(0, 0, 32'h0,  32'h0,        0, 0, 32'h0,  32'h0,        0, 9'b000000001, 8'd0,
        1, 32'hA000_0001, 1, 32'hA000_0008);
    // CPU-only load of 0x8.
    add(1, 0, 32'h8,  32'h0,        0, 0, 32'h0,  32'h0,        0, 9'b100001000, 8'd2,
        0, 32'h0, 0, 32'h0);
    add(0, 0, 32'h0,  32'h0,        0, 0, 32'h0,  32'h0,        0, 9'b000000010, 8'd0,
        1, 32'hA000_0002, 0, 32'h0);
    // Misaligned CPU request, then misaligned dbg alongside an aligned CPU load.
    add(1, 0, 32'h6,  32'h0,        0, 0, 32'h0,  32'h0,        0, 9'b001000000, 8'd0,
        0, 32'h0, 0, 32'h0);
    add(0, 0, 32'h0,  32'h0,        0, 0, 32'h0,  32'h0,        0, 9'b000000000, 8'd0,
        1, 32'hA000_0002, 0, 32'h0);
    add(1, 0, 32'hC,  32'h0,        1, 0, 32'h1,  32'h0,        0, 9'b100101000, 8'd3,
        0, 32'h0, 0, 32'h0);
    add(0, 0, 32'h0,  32'h0,        0, 0, 32'h0,  32'h0,        0, 9'b000000010, 8'd0,
        1, 32'hA000_0003, 0, 32'h0);
    // CPU store then load of 0x10.
    add(1, 1, 32'h10, 32'hDEADBEEF, 0, 0, 32'h0,  32'h0,        0, 9'b100001100, 8'd4,
        0, 32'h0, 0, 32'h0);
    add(1, 0, 32'h10, 32'h0,        0, 0, 32'h0,  32'h0,        0, 9'b100001000, 8'd4,
        0, 32'h0, 0, 32'h0);
    add(0, 0, 32'h0,  32'h0,        0, 0, 32'h0,  32'h0,        0, 9'b000000010, 8'd0,
        1, 32'hDEADBEEF, 0, 32'h0);
    // dbg_lock without dbg_req stays in arbitration.
    add(1, 0, 32'h0,  32'h0,        0, 0, 32'h0,  32'h0,        1, 9'b100001000, 8'd0,
        0, 32'h0, 0, 32'h0);
    add(1, 0, 32'h0,  32'h0,        0, 0, 32'h0,  32'h0,        1, 9'b100001010, 8'd0,
        1, 32'hA000_0000, 0, 32'h0);
    add(0, 0, 32'h0,  32'h0,        0, 0, 32'h0,  32'h0,        0, 9'b000000010, 8'd0,
        1, 32'hA000_0000, 0, 32'h0);
    // Locked burst of four dbg writes with the CPU held off.
    add(1, 0, 32'h14, 32'h0,        1, 1, 32'h0,  32'h1111_1111, 1, 9'b010011100, 8'd0,
        0, 32'h0, 0, 32'h0);
    add(1, 0, 32'h14, 32'h0,        1, 1, 32'h4,  32'h2222_2222, 1, 9'b010011100, 8'd1,
        0, 32'h0, 0, 32'h0);
    add(1, 0, 32'h14, 32'h0,        1, 1, 32'h8,  32'h3333_3333, 1, 9'b010011100, 8'd2,
        0, 32'h0, 0, 32'h0);
    add(1, 0, 32'h14, 32'h0,        1, 1, 32'hC,  32'h4444_4444, 1, 9'b010011100, 8'd3,
        0, 32'h0, 0, 32'h0);
    add(1, 0, 32'h14, 32'h0,        0, 0, 32'h0,  32'h0,        0, 9'b000010000, 8'd0,
        0, 32'h0, 0, 32'h0);
    add(1, 0, 32'h14, 32'h0,        1, 0, 32'h0,  32'h0,        0, 9'b100001000, 8'd5,
        0, 32'h0, 0, 32'h0);
    // Read back the burst through the dbg port.
    add(0, 0, 32'h0,  32'h0,        1, 0, 32'h0,  32'h0,        0, 9'b010001010, 8'd0,
        1, 32'hA000_0005, 0, 32'h0);
    add(0, 0, 32'h0,  32'h0,        1, 0, 32'h4,  32'h0,        0, 9'b010001001, 8'd1,
        0, 32'h0, 1, 32'h1111_1111);
    add(0, 0, 32'h0,  32'h0,        1, 0, 32'h8,  32'h0,        0, 9'b010001001, 8'd2,
        0, 32'h0, 1, 32'h2222_2222);
    add(0, 0, 32'h0,  32'h0,        1, 0, 32'hC,  32'h0,        0, 9'b010001001, 8'd3,
        0, 32'h0, 1, 32'h3333_3333);
    add(0, 0, 32'h0,  32'h0,        0, 0, 32'h0,  32'h0,        0, 9'b000000001, 8'd0,
        0, 32'h0, 1, 32'h4444_4444);

    idle();
    reset    = 1'b0;
    mem_init = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    mem_init = 1'b0;
    reset    = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      v = vecs[i];
      drive(v.cr, v.cw, v.ca, v.cd, v.dr, v.dw, v.da, v.dd, v.dl);
      @(negedge clk);
      chk($sformatf("row%0d cpu_gnt", i),    {31'b0, bus.cpu_gnt},    {31'b0, v.flags[8]});
      chk($sformatf("row%0d dbg_gnt", i),    {31'b0, bus.dbg_gnt},    {31'b0, v.flags[7]});
      chk($sformatf("row%0d cpu_err", i),    {31'b0, bus.cpu_err},    {31'b0, v.flags[6]});
      chk($sformatf("row%0d dbg_err", i),    {31'b0, bus.dbg_err},    {31'b0, v.flags[5]});
      chk($sformatf("row%0d cpu_stall", i),  {31'b0, bus.cpu_stall},  {31'b0, v.flags[4]});
      chk($sformatf("row%0d mem_en", i),     {31'b0, bus.mem_en},     {31'b0, v.flags[3]});
      chk($sformatf("row%0d mem_we", i),     {31'b0, bus.mem_we},     {31'b0, v.flags[2]});
      chk($sformatf("row%0d mem_addr", i),   {24'b0, bus.mem_addr},   {24'b0, v.addr});
      chk($sformatf("row%0d cpu_rvalid", i), {31'b0, bus.cpu_rvalid}, {31'b0, v.flags[1]});
      chk($sformatf("row%0d dbg_rvalid", i), {31'b0, bus.dbg_rvalid}, {31'b0, v.flags[0]});
      exp_wd = 32'h0;
      if (v.flags[2]) exp_wd = v.flags[8] ? v.cd : v.dd;
      chk($sformatf("row%0d mem_wdata", i), bus.mem_wdata, exp_wd);
      if (v.k_crd) chk($sformatf("row%0d cpu_rdata", i), bus.cpu_rdata, v.crd);
      if (v.k_drd) chk($sformatf("row%0d dbg_rdata", i), bus.dbg_rdata, v.drd);
      @(posedge clk);
      #1;
    end

    // Reset in the cycle after a granted, locking dbg load.
    drive(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 32'h4, 32'h0, 1'b1);
    @(negedge clk);
    chk("rst dbg_gnt before reset", {31'b0, bus.dbg_gnt}, 32'h1);
    @(posedge clk);
    #1;
    idle();
    reset = 1'b0;
    #1;
    chk("rst dbg_rvalid dropped", {31'b0, bus.dbg_rvalid}, 32'h0);
    chk("rst dbg_rdata cleared", bus.dbg_rdata, 32'h0);
    chk("rst mem_en idle", {31'b0, bus.mem_en}, 32'h0);
    @(posedge clk);
    #1;
    reset = 1'b1;
    drive(1'b1, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 32'h4, 32'h0, 1'b1);
    @(negedge clk);
    chk("rst conflict cpu_gnt", {31'b0, bus.cpu_gnt}, 32'h1);
    chk("rst conflict dbg_gnt", {31'b0, bus.dbg_gnt}, 32'h0);
    chk("rst conflict dbg_rvalid", {31'b0, bus.dbg_rvalid}, 32'h0);
    @(posedge clk);
    #1;
    idle();
    @(negedge clk);
    chk("rst cpu_rvalid after", {31'b0, bus.cpu_rvalid}, 32'h1);
    chk("rst cpu_rdata after", bus.cpu_rdata, 32'h1111_1111);
    chk("rst dbg_rvalid after", {31'b0, bus.dbg_rvalid}, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
